// File: rtl/window_mac_pkg.sv
// Shared widths and helpers for the window_mac convolution block.
// WINDOW_MAC_SATURATE_EN selects clamping instead of wrap in fit_out.
package window_mac_pkg;

  localparam int PIX_W  = 8;
  localparam int PROD_W = 16;
  localparam int FIT_W  = 64;

  function automatic int acc_width(input int depth);
    return PROD_W + $clog2(depth * depth);
  endfunction

  function automatic int colsum_width(input int depth);
    return PROD_W + $clog2(depth);
  endfunction

  function automatic logic [FIT_W-1:0] fit_out(
    input logic [FIT_W-1:0] value,
    input int               out_w
  );
    logic [FIT_W-1:0] lim;
    if (out_w >= FIT_W) return value;
    lim = (64'd1 << out_w) - 64'd1;
`ifdef WINDOW_MAC_SATURATE_EN
    return (value > lim) ? lim : value;
`else
    return value & lim;
`endif
  endfunction

endpackage

// File: rtl/window_mac_column_dot.sv
// Combinational dot product of one pixel column with one weight column.
// DEPTH unsigned 8x8 multipliers feeding a summation tree.
module column_dot
  import window_mac_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic [PIX_W*DEPTH-1:0]            p_col,
  input  logic [PIX_W*DEPTH-1:0]            w_col,
  output logic [colsum_width(DEPTH)-1:0]    colsum
);

  localparam int CS_W = colsum_width(DEPTH);

  logic [PROD_W-1:0] prod [DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_mul
    assign prod[j] = PROD_W'(p_col[PIX_W*j +: PIX_W])
                   * PROD_W'(w_col[PIX_W*j +: PIX_W]);
  end

  always_comb begin
    colsum = '0;
    for (int j = 0; j < DEPTH; j++) begin
      colsum = colsum + CS_W'(prod[j]);
    end
  end

endmodule

// File: rtl/window_mac.sv
// Non-overlapping DEPTH x DEPTH window multiply-accumulate over column beats.
// Build with WINDOW_MAC_SATURATE_EN to clamp results instead of wrapping.
module window_mac
  import window_mac_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int OUT_W = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           w_load,
  input  logic [PIX_W*DEPTH*DEPTH-1:0]   w_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIX_W*DEPTH-1:0]         p_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data
);

  localparam int ACC_W = acc_width(DEPTH);
  localparam int CS_W  = colsum_width(DEPTH);
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W = PIX_W * DEPTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0]               col_cnt_q, col_cnt_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [PIX_W*DEPTH*DEPTH-1:0]   w_q, w_d;
  logic                           out_valid_q, out_valid_d;
  logic [OUT_W-1:0]               out_data_q, out_data_d;

  logic [COL_W-1:0] w_col;
  logic [CS_W-1:0]  colsum;
  logic [ACC_W-1:0] sum;
  logic             accept;

  always_comb begin
    w_col = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (col_cnt_q == CNT_W'(k)) begin
        w_col = w_q[COL_W*k +: COL_W];
      end
    end
  end

  column_dot #(
    .DEPTH (DEPTH)
  ) u_dot (
    .p_col  (p_in),
    .w_col  (w_col),
    .colsum (colsum)
  );

  assign in_ready  = !w_load && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign sum       = acc_q + ACC_W'(colsum);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    col_cnt_d   = col_cnt_q;
    acc_d       = acc_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (w_load) begin
      w_d = w_in;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // flush wins over a same-cycle beat, which is simply dropped
    if (flush) begin
      col_cnt_d = '0;
      acc_d     = '0;
    end else if (accept) begin
      if (col_cnt_q == LAST) begin
        out_data_d  = OUT_W'(fit_out(FIT_W'(sum), OUT_W));
        out_valid_d = 1'b1;
        acc_d       = '0;
        col_cnt_d   = '0;
      end else begin
        acc_d     = sum;
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_cnt_q   <= '0;
      acc_q       <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_window_mac.sv
// Directed scoreboard bench for window_mac (DEPTH=3, OUT_W=16).
// Expected window results are queued at stimulus time and popped on handshake.
module tb_window_mac;

  localparam int DEPTH = 3;
  localparam int OUT_W = 16;
  localparam int KW    = 8 * DEPTH * DEPTH;
  localparam int CW    = 8 * DEPTH;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            w_load;
  logic [KW-1:0]   w_in;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   p_in;
  logic            out_valid;
  logic            out_ready;
  logic [OUT_W-1:0] out_data;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] sb [$];

  always #5 clock = ~clock;

  window_mac #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .w_load    (w_load),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [CW-1:0] col(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [KW-1:0] kern_all(input int v);
    logic [KW-1:0] k;
    for (int i = 0; i < DEPTH * DEPTH; i++) k[8*i +: 8] = 8'(v);
    return k;
  endfunction

  function automatic logic [KW-1:0] kern_ramp();
    logic [KW-1:0] k;
    for (int c = 0; c < DEPTH; c++)
      for (int j = 0; j < DEPTH; j++)
        k[8*(c*DEPTH+j) +: 8] = 8'(c + 1);
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [OUT_W-1:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_out observed=%0h expected=none", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    mon();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [KW-1:0] k);
    w_load = 1'b1;
    w_in   = k;
    @(negedge clock);
    mon();
    chk("wload_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    w_load = 1'b0;
  endtask

  task automatic send_col(input logic [CW-1:0] c);
    bit got = 1'b0;
    int n   = 0;
    in_valid = 1'b1;
    p_in     = c;
    while (!got && n < 50) begin
      @(negedge clock);
      mon();
      got = (in_ready === 1'b1);
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_std(input logic [OUT_W-1:0] exp);
    sb.push_back(exp);
    send_col(col(0, 1, 2));
    send_col(col(1, 2, 3));
    send_col(col(2, 3, 4));
  endtask

  initial begin
    logic [OUT_W-1:0] ovf_exp;
`ifdef WINDOW_MAC_SATURATE_EN
    ovf_exp = 16'hFFFF;
`else
    ovf_exp = 16'hEE09;
`endif
    reset = 1'b1; flush = 1'b0; w_load = 1'b0; w_in = '0;
    in_valid = 1'b0; p_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // basic window, single-cycle out_valid pulse
    load(kern_all(1));
    send_std(16'd18);
    chk("basic_valid", 32'(out_valid), 32'd1);
    step();
    chk("basic_drop", 32'(out_valid), 32'd0);

    // weighted sum
    load(kern_ramp());
    send_std(16'd42);
    step();

    // backpressure, with a column already waiting
    load(kern_all(1));
    out_ready = 1'b0;
    sb.push_back(16'd18);
    send_col(col(0, 1, 2));
    send_col(col(1, 2, 3));
    send_col(col(2, 3, 4));
    in_valid = 1'b1;
    p_in     = col(0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'd18);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    sb.push_back(16'd18);
    send_col(col(0, 1, 2));
    chk("bp_drop", 32'(out_valid), 32'd0);
    send_col(col(1, 2, 3));
    send_col(col(2, 3, 4));
    step();

    // overflow
    load(kern_all(255));
    sb.push_back(ovf_exp);
    for (int i = 0; i < DEPTH; i++) send_col(col(255, 255, 255));
    step();

    // reset mid-window
    load(kern_all(1));
    send_col(col(5, 5, 5));
    send_col(col(7, 7, 7));
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    load(kern_all(1));
    send_std(16'd18);
    step();

    // flush mid-window; same-cycle beat must be dropped
    send_col(col(5, 5, 5));
    send_col(col(7, 7, 7));
    flush    = 1'b1;
    in_valid = 1'b1;
    p_in     = col(9, 9, 9);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    send_std(16'd18);
    step();

    // w_load beats a presented column
    w_load   = 1'b1;
    w_in     = kern_ramp();
    in_valid = 1'b1;
    p_in     = col(0, 1, 2);
    @(negedge clock);
    mon();
    chk("wprio_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    w_load = 1'b0;
    send_std(16'd42);
    step();

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_mac.md
Name: window_mac

Overview:
- Downstream consumer of the parallel-out shift register.
- Takes one DEPTH-byte column per accepted beat (the shift register's p_out).
- Multiplies each column element-wise by the matching column of a DEPTH x DEPTH weight kernel and accumulates over DEPTH columns.
- Emits one convolution result per window (non-overlapping, stride DEPTH) with a valid/ready output handshake.

Parameters:
- DEPTH, 3, window height and width; also the number of bytes per input column.
- OUT_W, 16, width of out_data.
- Localparam ACC_W = 16 + $clog2(DEPTH*DEPTH), the internal lossless accumulator width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; aborts the partial window.
- w_load  in  1  capture w_in into the weight registers.
- w_in  in  8*DEPTH*DEPTH  kernel; byte k*DEPTH+j is the weight for column k, element j.
- in_valid  in  1  p_in holds a valid column.
- in_ready  out  1  block can accept a column this cycle.
- p_in  in  8*DEPTH  column; byte j is bits [8j+7:8j], unsigned.
- out_valid  out  1  out_data holds a completed window result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  window result, unsigned.

Behaviour:
- Reset: asynchronous, active-high. Clears col_cnt=0, acc=0, out_valid=0, out_data=0 and all weights=0. Reset asserted mid-window discards the partial window; no output is produced for it.
- Data: all values unsigned. Each 8x8 product is 16 bits. colsum = sum over j of p_in[j]*w[col_cnt*DEPTH+j], computed combinationally.
- in_ready = !w_load && (!out_valid || out_ready).
- Column accept (in_valid && in_ready):
  - If col_cnt < DEPTH-1: acc <= acc + colsum; col_cnt++.
  - If col_cnt == DEPTH-1: out_data <= fit(acc + colsum); out_valid <= 1; acc <= 0; col_cnt <= 0.
- Latency: out_valid rises on the clock edge that accepts the last column of the window (1-cycle registered).
- Output handshake:
  - out_valid && out_ready with no new completion in the same cycle: out_valid <= 0.
  - A completion in the same cycle as out_ready: out_valid stays 1 and out_data updates back-to-back.
  - out_data holds stable while out_valid && !out_ready.
- Stall: while out_valid && !out_ready, in_ready = 0 for every column, including mid-window columns.
- w_load:
  - Weights <= w_in on the next edge; w_load forces in_ready low that cycle.
  - col_cnt and acc are unaffected, so a mid-window load uses new weights for the remaining columns. This is legal but the caller's responsibility.
- flush: col_cnt <= 0 and acc <= 0. Has priority over a same-cycle column accept, which is dropped (no state change). out_valid and out_data are untouched.
- fit(): truncation to the low OUT_W bits by default (see Optional Feature). If OUT_W >= ACC_W, zero-extend.
- col_cnt is $clog2(DEPTH) bits wide; DEPTH=1 is legal (every accepted beat completes a window).

Optional Feature:
- Macro: WINDOW_MAC_SATURATE_EN.
- Defined: fit() clamps to 2^OUT_W - 1 when acc + colsum >= 2^OUT_W.
- Undefined: fit() takes the low OUT_W bits (modular wrap).
- Accumulator width is identical in both builds.

Decomposition:
- Package window_mac_pkg:
  - function acc_width(depth).
  - PIX_W = 8 and PROD_W = 16.
  - Saturate/truncate function fit_out(value, out_w).
- Sub-module column_dot: DEPTH multipliers plus adder tree, purely combinational. Inputs are the column and the selected weight column; output is colsum (PROD_W + $clog2(DEPTH) bits).
- window_mac instantiates one column_dot and owns col_cnt, acc, weights and the output register.

Test Plan:
- Basic window: reset, w_load all weights = 1, columns {0,1,2}, {1,2,3}, {2,3,4} on consecutive cycles, out_ready=1 -> out_valid for one cycle after the third accept, out_data = 18.
- Weighted sum: weights column k = k+1, same three columns -> out_data = 3 + 12 + 27 = 42.
- Backpressure: hold out_ready=0 after a result -> in_ready=0 and out_data stable at 18 for 5 cycles. Raise out_ready -> out_valid drops next edge. Next window completes correctly with no lost or duplicated column.
- Overflow: all weights 255, all pixels 255 (window sum 585225):
  - Default build -> out_data = 0xEE09.
  - With WINDOW_MAC_SATURATE_EN -> out_data = 0xFFFF.
- Reset mid-window: accept 2 columns, pulse reset, then feed {0,1,2}, {1,2,3}, {2,3,4} with weights reloaded to 1 -> out_data = 18, and no output for the aborted window. Repeat with flush instead of reset -> same result, weights retained without reload.
- w_load priority: assert w_load and in_valid together -> in_ready=0, column not consumed, weights updated; the column is accepted the next cycle.
